// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 register file and exception sequencer for the multi-cycle
// MIPS core. Holds Status (12), Cause (13) and EPC (14) alongside 29 plain
// read/write registers. It accepts syscall/break/teq requests against the
// Status enable and mask bits, and steers the PC mux to the handler vector
// on entry or to EPC on eret.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
  parameter logic [31:0] STATUS_RESET = 32'h0000_000F,
  parameter int          SHIFT        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        exc_req,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] pc_in,
  input  logic        eret,
  output logic        exc_taken,
  output logic [31:0] exc_addr,
  output logic [31:0] status_out,
  output logic [31:0] epc_out,
  output logic        in_handler
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [4:0] CODE_SYSCALL = 5'd8;
  localparam logic [4:0] CODE_BREAK   = 5'd9;
  localparam logic [4:0] CODE_TEQ     = 5'd13;

  logic [31:0] regs_r [0:31];
  logic        in_handler_r;

  logic        mask_s;
  logic        taken_s;
  logic        eret_act_s;
  logic        wr_special_s;
  logic        wr_allow_s;
  logic [31:0] status_s;
  logic [31:0] epc_s;

  assign status_s = regs_r[ADDR_STATUS];
  assign epc_s    = regs_r[ADDR_EPC];

  // Select the Status mask bit that governs the requested exception code.
  always_comb begin
    mask_s = 1'b0;
    case (exc_cause)
      CODE_SYSCALL: mask_s = status_s[1];
      CODE_BREAK:   mask_s = status_s[2];
      CODE_TEQ:     mask_s = status_s[3];
      default:      mask_s = 1'b0;
    endcase
  end

  // Decide acceptance and which events are allowed to act this cycle.
  always_comb begin
    taken_s      = exc_req & status_s[0] & mask_s;
    eret_act_s   = eret & ~taken_s;
    wr_special_s = (cp0_addr == ADDR_STATUS) || (cp0_addr == ADDR_CAUSE) ||
                   (cp0_addr == ADDR_EPC);
    if (taken_s && wr_special_s) begin
      // Exception entry owns Status/Cause/EPC this cycle.
      wr_allow_s = 1'b0;
    end else if (eret_act_s && (cp0_addr == ADDR_STATUS)) begin
      // Eret owns Status only; other addresses still take the write.
      wr_allow_s = 1'b0;
    end else begin
      wr_allow_s = cp0_we;
    end
  end

  // Drive the PC-mux target: handler vector on entry, otherwise EPC.
  always_comb begin
    if (taken_s) begin
      exc_addr = EXC_VECTOR;
    end else begin
      exc_addr = epc_s;
    end
  end

  assign exc_taken  = taken_s;
  assign cp0_rdata  = regs_r[cp0_addr];
  assign status_out = status_s;
  assign epc_out    = epc_s;
  assign in_handler = in_handler_r;

  // Register file update: reset, mtc0, exception entry and eret.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
      regs_r[ADDR_STATUS] <= STATUS_RESET;
      in_handler_r        <= 1'b0;
    end else begin
      if (wr_allow_s) begin
        regs_r[cp0_addr] <= cp0_wdata;
      end else begin
        regs_r[cp0_addr] <= regs_r[cp0_addr];
      end
      if (taken_s) begin
        regs_r[ADDR_EPC]    <= pc_in;
        regs_r[ADDR_CAUSE]  <= {25'd0, exc_cause, 2'b00};
        regs_r[ADDR_STATUS] <= status_s << SHIFT;
        in_handler_r        <= 1'b1;
      end else if (eret_act_s) begin
        regs_r[ADDR_STATUS] <= status_s >> SHIFT;
        in_handler_r        <= 1'b0;
      end else begin
        in_handler_r        <= in_handler_r;
      end
    end
  end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Coprocessor-0 register file and exception sequencer for the multi-cycle MIPS core.
- Sits directly downstream of the controller. It consumes the controller's CP0 strobes for mtc0/mfc0 and the exception/eret decisions for syscall, break and teq.
- Holds Status, Cause and EPC, and supplies the exception vector and return address to the PC-write mux.

Parameters:
- EXC_VECTOR, 32'h0000_0004: handler address driven on exc_addr during exception entry.
- STATUS_RESET, 32'h0000_000F: Status value after reset (global enable plus all three masks set).
- SHIFT, 5: bit shift applied to Status on exception entry (left) and eret (right).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- cp0_we  in  1  mtc0 write strobe (controller CP0_Rd_in).
- cp0_addr  in  5  CP0 register number (instruction rd field).
- cp0_wdata  in  32  mtc0 data (rt value).
- cp0_rdata  out  32  mfc0 read data. Combinational from cp0_addr.
- exc_req  in  1  one-cycle exception request from the controller.
- exc_cause  in  5  ExcCode: 8 = syscall, 9 = break, 13 = teq.
- pc_in  in  32  address of the faulting instruction.
- eret  in  1  one-cycle eret strobe.
- exc_taken  out  1  combinational: exc_req accepted this cycle.
- exc_addr  out  32  EXC_VECTOR when exc_taken, else EPC.
- status_out  out  32  current Status.
- epc_out  out  32  current EPC.
- in_handler  out  1  registered: 1 between a taken exception and the following eret.

Behaviour:
- Storage: a 32x32 register array. Registers 12 (Status), 13 (Cause) and 14 (EPC) have special update rules. All others are plain read/write.
- Reset (synchronous, rst = 1 at the clock edge):
  - Status = STATUS_RESET.
  - Every other register = 0.
  - in_handler = 0.
  - Reset mid-handler discards any pending state; nothing survives reset.
- Read path:
  - cp0_rdata = reg[cp0_addr].
  - A read during a same-cycle write returns the old value.
- Acceptance:
  - Mask bits: syscall uses Status[1], break uses Status[2], teq uses Status[3].
  - exc_taken = exc_req & Status[0] & mask bit for exc_cause.
  - Any other exc_cause value is never taken.
  - A request that is not taken changes no state. The controller then continues sequentially.
- Exception entry (exc_taken = 1), at the clock edge:
  - EPC = pc_in.
  - Cause[6:2] = exc_cause; all other Cause bits are cleared.
  - Status = Status << SHIFT, zero-fill. With the reset value this clears enable and masks, so nested exceptions are blocked.
  - in_handler = 1.
  - Combinationally in the same cycle, exc_addr = EXC_VECTOR.
- Eret (eret = 1, exc_taken = 0), at the clock edge:
  - Status = Status >> SHIFT, logical.
  - in_handler = 0.
  - exc_addr = EPC combinationally in that cycle.
  - EPC and Cause are unchanged.
  - Eret with in_handler = 0 still shifts Status. This is permitted, not an error.
- mtc0 (cp0_we = 1): reg[cp0_addr] = cp0_wdata at the clock edge.
- Priority for simultaneous events:
  - rst beats everything.
  - exc_taken beats eret; the eret is dropped.
  - exc_taken beats a same-cycle mtc0 to 12, 13 or 14; that write is dropped.
  - An mtc0 to any other address proceeds alongside an exception.
  - Eret beats a same-cycle mtc0 to Status only.
- Latency:
  - All state updates take one cycle.
  - exc_taken and exc_addr are valid in the request cycle, so the controller can load PC on the same edge.

Test Plan:
- Reset and read:
  - Assert rst for 2 cycles, then read addresses 12, 13 and 14.
  - Required: cp0_rdata = 0x0000000F, 0, 0; in_handler = 0.
- Syscall entry and return:
  - Drive exc_req = 1, exc_cause = 8, pc_in = 0x00400020.
  - Required in the request cycle: exc_taken = 1, exc_addr = 0x00000004.
  - Required after the edge: EPC = 0x00400020, Cause = 0x20, Status = 0x1E0, in_handler = 1.
  - Then pulse eret. Required in the eret cycle: exc_addr = 0x00400020. Required after the edge: Status = 0xF, in_handler = 0.
- Masked teq:
  - mtc0 Status = 0x7 (teq mask cleared), then exc_req with cause 13.
  - Required: exc_taken = 0; EPC, Cause and Status unchanged.
- Nested request blocked:
  - Take a break (cause 9), then request syscall while in_handler = 1.
  - Required: second request not taken; EPC still holds the break PC; Cause = 0x24.
- Simultaneous events:
  - exc_req (cause 8, taken) with eret and an mtc0 to address 14 = 0xDEAD in the same cycle.
  - Required: EPC = pc_in, not 0xDEAD; Status shifted left; eret ignored.
  - In a separate cycle, an mtc0 to address 5 alongside a taken exception. Required: reg 5 updated.
- Reset mid-handler:
  - After a taken exception, assert rst.
  - Required: Status = 0xF, EPC = 0, in_handler = 0 on the next cycle.
